// File: rtl/tetris_pkg.sv
// Shared piece definitions for the piece bag scheduler and its queue.
// Bag semantics in piece_bag_scheduler are enabled with macro PIECE_BAG_EN.
package tetris_pkg;

   localparam int NUM_PIECES = 7;
   localparam logic [6:0] BAG_FULL = 7'h7F;

   typedef enum logic [2:0] {
      PIECE_I = 3'd0,
      PIECE_O = 3'd1,
      PIECE_T = 3'd2,
      PIECE_S = 3'd3,
      PIECE_Z = 3'd4,
      PIECE_J = 3'd5,
      PIECE_L = 3'd6
   } piece_t;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_FILL = 2'd1,
      ST_HOLD = 2'd2
   } sched_state_t;

   // Lowest-index piece still present in the bag; an empty bag yields piece 0.
   function automatic piece_t lowest_set(input logic [6:0] bag);
      piece_t res;
      res = PIECE_I;
      for (int i = NUM_PIECES - 1; i >= 0; i--) begin
         if (bag[i]) res = piece_t'(3'(i));
      end
      return res;
   endfunction

endpackage

// File: rtl/piece_queue.sv
// Shift-register piece FIFO: slot 0 is the head, all slots readable in parallel.
// Invalid slots always hold 0 because a pop shifts zero into the top slot.
module piece_queue
   import tetris_pkg::*;
#(
   parameter int depth_p = 4
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               push,
   input  piece_t                             push_piece,
   input  logic                               pop,
   output logic [depth_p*3-1:0]               slots,
   output logic [$clog2(depth_p+1)-1:0]       count
);

   localparam int CW = $clog2(depth_p + 1);

   logic [2:0]    slot_r [depth_p];
   logic [2:0]    slot_n [depth_p];
   logic [CW-1:0] count_r;
   logic [CW-1:0] count_n;
   logic [CW-1:0] tail;

   always_comb begin
      tail = count_r - CW'(pop);
      for (int i = 0; i < depth_p - 1; i++) begin
         slot_n[i] = pop ? slot_r[i+1] : slot_r[i];
      end
      slot_n[depth_p-1] = pop ? 3'd0 : slot_r[depth_p-1];
      // With a same-cycle pop the tail position has already moved down by one.
      if (push) begin
         for (int i = 0; i < depth_p; i++) begin
            if (CW'(i) == tail) slot_n[i] = push_piece;
         end
      end
      count_n = count_r + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < depth_p; i++) slot_r[i] <= 3'd0;
         count_r <= '0;
      end else begin
         for (int i = 0; i < depth_p; i++) slot_r[i] <= slot_n[i];
         count_r <= count_n;
      end
   end

   always_comb begin
      for (int i = 0; i < depth_p; i++) slots[3*i +: 3] = slot_r[i];
   end

   assign count = count_r;

endmodule

// File: rtl/piece_bag_scheduler.sv
// Draws pieces from a random word into a preview queue, optionally with 7-bag
// fairness (macro PIECE_BAG_EN) and a fallback pick after repeated rejections.
module piece_bag_scheduler
   import tetris_pkg::*;
#(
   parameter int width_p      = 32,
   parameter int depth_p      = 4,
   parameter int max_reject_p = 8
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic [width_p-1:0]       random_i,
   input  logic                     piece_ready_i,
   output logic                     piece_v_o,
   output logic [2:0]               piece_o,
   output logic [(depth_p-1)*3-1:0] preview_o,
   output logic                     preview_v_o
);

   localparam int CW = $clog2(depth_p + 1);
   localparam int RW = (max_reject_p > 1) ? $clog2(max_reject_p) : 1;

   // Handshake: the head piece transfers on a cycle where piece_v_o and
   // piece_ready_i are both high; piece_v_o never depends on piece_ready_i.

   sched_state_t      state_r, state_n;
   logic [6:0]        bag_r, bag_n;
   logic [RW-1:0]     reject_cnt_r, reject_cnt_n;

   logic [depth_p*3-1:0] slots;
   logic [CW-1:0]        count;

   logic       pop;
   logic       draw_en;
   logic [2:0] cand;
   logic [7:0] bag_ext;
   logic       cand_ok;
   logic       fallback;
   logic       push;
   piece_t     push_piece;
   logic [6:0] bag_clr;
   logic       unused_random;

   assign unused_random = ^random_i[width_p-1:3];

   assign piece_v_o   = (count != '0);
   assign preview_v_o = (count == CW'(depth_p));
   assign piece_o     = slots[2:0];
   assign preview_o   = slots[depth_p*3-1:3];
   assign pop         = piece_v_o & piece_ready_i;

   always_comb begin
      state_n = state_r;
      draw_en = 1'b0;
      case (state_r)
         ST_INIT: state_n = ST_FILL;
         ST_FILL: begin
            draw_en = (count < CW'(depth_p)) || pop;
            if ((count == CW'(depth_p)) && !pop) state_n = ST_HOLD;
         end
         ST_HOLD: begin
            if (pop) state_n = ST_FILL;
         end
         default: state_n = ST_INIT;
      endcase
   end

   always_comb begin
      cand     = random_i[2:0];
      // Bit 7 of the extended bag is always 0 so candidate 7 never matches.
      bag_ext  = {1'b0, bag_r};
      cand_ok  = bag_ext[cand];
      fallback = draw_en && !cand_ok && (reject_cnt_r == RW'(max_reject_p - 1));
      push     = draw_en && (cand_ok || fallback);
      push_piece = cand_ok ? piece_t'(cand) : lowest_set(bag_r);

      reject_cnt_n = reject_cnt_r;
      if (push) reject_cnt_n = '0;
      else if (draw_en) reject_cnt_n = reject_cnt_r + RW'(1);

      bag_clr = bag_r & ~(7'd1 << push_piece);
`ifdef PIECE_BAG_EN
      bag_n = bag_r;
      if (push) bag_n = (bag_clr == 7'd0) ? BAG_FULL : bag_clr;
`else
      bag_n = BAG_FULL;
`endif
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r      <= ST_INIT;
         bag_r        <= BAG_FULL;
         reject_cnt_r <= '0;
      end else begin
         state_r      <= state_n;
         bag_r        <= bag_n;
         reject_cnt_r <= reject_cnt_n;
      end
   end

   piece_queue #(
      .depth_p (depth_p)
   ) u_queue (
      .clk        (clk_i),
      .reset      (reset_i),
      .push       (push),
      .push_piece (push_piece),
      .pop        (pop),
      .slots      (slots),
      .count      (count)
   );

endmodule

// File: tb/tb_piece_bag_scheduler.sv
// Bench for piece_bag_scheduler: directed sequences plus randomized traffic
// checked every cycle against a queue/bag model; honours PIECE_BAG_EN.
module tb_piece_bag_scheduler;

   localparam int W = 32;
   localparam int D = 4;
   localparam int M = 8;

   logic             clk = 1'b0;
   logic             reset_i = 1'b1;
   logic [W-1:0]     random_i = '0;
   logic             piece_ready_i = 1'b0;
   logic             piece_v_o;
   logic [2:0]       piece_o;
   logic [3*(D-1)-1:0] preview_o;
   logic             preview_v_o;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   piece_bag_scheduler #(
      .width_p      (W),
      .depth_p      (D),
      .max_reject_p (M)
   ) dut (
      .clk_i         (clk),
      .reset_i       (reset_i),
      .random_i      (random_i),
      .piece_ready_i (piece_ready_i),
      .piece_v_o     (piece_v_o),
      .piece_o       (piece_o),
      .preview_o     (preview_o),
      .preview_v_o   (preview_v_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a list of queued pieces, the set of undealt pieces,
   // a reject streak, and whether drawing is currently paused or warming up.
   logic [2:0] exp_q[$];
   bit         m_bag[7];
   int         m_rej;
   int         m_phase;   // 0 warm-up, 1 drawing, 2 paused while full
   bit         m_started = 1'b0;

   always @(posedge clk) begin : model
      bit m_pop, m_draw, m_pushed, any_left;
      int cand, pc;
      if (reset_i) begin
         exp_q.delete();
         for (int i = 0; i < 7; i++) m_bag[i] = 1'b1;
         m_rej = 0;
         m_phase = 0;
         m_started = 1'b1;
      end else if (m_started) begin
         m_pop = (exp_q.size() > 0) && piece_ready_i;
         m_draw = (m_phase == 1) && ((exp_q.size() < D) || m_pop);
         m_pushed = 1'b0;
         pc = 0;
         if (m_draw) begin
            cand = int'(random_i[2:0]);
            if (cand < 7 && m_bag[cand]) begin
               pc = cand;
               m_pushed = 1'b1;
            end else if (m_rej == M - 1) begin
               for (int i = 6; i >= 0; i--) if (m_bag[i]) pc = i;
               m_pushed = 1'b1;
            end else begin
               m_rej++;
            end
         end
         if (m_pushed) begin
            m_rej = 0;
`ifdef PIECE_BAG_EN
            m_bag[pc] = 1'b0;
            any_left = 1'b0;
            for (int i = 0; i < 7; i++) any_left |= m_bag[i];
            if (!any_left) for (int i = 0; i < 7; i++) m_bag[i] = 1'b1;
`endif
         end
         if (m_phase == 0) m_phase = 1;
         else if (m_phase == 1 && exp_q.size() == D && !m_pop) m_phase = 2;
         else if (m_phase == 2 && m_pop) m_phase = 1;
         if (m_pop) void'(exp_q.pop_front());
         if (m_pushed) exp_q.push_back(3'(pc));
      end
   end

   always @(negedge clk) begin : compare
      logic [3*(D-1)-1:0] exp_prev;
      if (m_started) begin
         exp_prev = '0;
         for (int i = 0; i < D - 1; i++) begin
            if (exp_q.size() > i + 1) exp_prev[3*i +: 3] = exp_q[i+1];
         end
         chk("model_piece_v", 32'(piece_v_o), 32'(exp_q.size() > 0));
         chk("model_piece", 32'(piece_o), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'd0);
         chk("model_preview", 32'(preview_o), 32'(exp_prev));
         chk("model_preview_v", 32'(preview_v_o), 32'(exp_q.size() == D));
      end
   end

   task automatic cyc(input logic [W-1:0] r, input logic rdy, input logic rst);
      random_i = r;
      piece_ready_i = rdy;
      reset_i = rst;
      @(posedge clk);
      #2;
   endtask

   function automatic logic [W-1:0] rnd_with(input logic [2:0] low);
      logic [W-1:0] r;
      r = W'($urandom);
      r[2:0] = low;
      return r;
   endfunction

   int exp_p[8];
   int exp_g[7];
   int exp_first;

   // Reset, then hold the candidate with ready high and log the first 8 deals.
   task automatic run_seq(input string tag, input logic [2:0] cand);
      int got_p[8];
      int got_t[8];
      int n;
      n = 0;
      cyc(rnd_with(cand), 1'b0, 1'b1);
      for (int k = 0; k < 300 && n < 8; k++) begin
         if (piece_v_o) begin
            got_p[n] = int'(piece_o);
            got_t[n] = k;
            n++;
         end
         cyc(rnd_with(cand), 1'b1, 1'b0);
      end
      chk({tag, "_count"}, 32'(n), 32'd8);
      if (n == 8) begin
         chk({tag, "_first_latency"}, 32'(got_t[0]), 32'(exp_first));
         for (int i = 0; i < 8; i++) chk($sformatf("%s_piece%0d", tag, i), 32'(got_p[i]), 32'(exp_p[i]));
         for (int i = 0; i < 7; i++) chk($sformatf("%s_gap%0d", tag, i), 32'(got_t[i+1] - got_t[i]), 32'(exp_g[i]));
      end
   endtask

   initial begin
      cyc('0, 1'b0, 1'b1);
      cyc('0, 1'b0, 1'b1);
      chk("reset_piece_v", 32'(piece_v_o), 32'd0);
      chk("reset_preview_v", 32'(preview_v_o), 32'd0);
      chk("reset_piece", 32'(piece_o), 32'd0);
      chk("reset_preview", 32'(preview_o), 32'd0);

      // Fill in order: warm-up cycle, then candidates 0,1,2,3.
      cyc(W'($urandom), 1'b0, 1'b0);
      chk("latency_warmup", 32'(piece_v_o), 32'd0);
      cyc(rnd_with(3'd0), 1'b0, 1'b0);
      chk("latency_first", 32'(piece_v_o), 32'd1);
      chk("first_piece", 32'(piece_o), 32'd0);
      cyc(rnd_with(3'd1), 1'b0, 1'b0);
      cyc(rnd_with(3'd2), 1'b0, 1'b0);
      cyc(rnd_with(3'd3), 1'b0, 1'b0);
      chk("fill_head", 32'(piece_o), 32'd0);
      chk("fill_preview", 32'(preview_o), 32'({3'd3, 3'd2, 3'd1}));
      chk("fill_preview_v", 32'(preview_v_o), 32'd1);

      // Full queue, pop with an accepted candidate 5 in the same cycle.
      cyc(rnd_with(3'd5), 1'b1, 1'b0);
      chk("swap_tail", 32'(preview_o[8:6]), 32'd5);
      chk("swap_full", 32'(preview_v_o), 32'd1);
      chk("swap_head", 32'(piece_o), 32'd1);
      cyc(rnd_with(3'd4), 1'b0, 1'b0);

      // Reset mid-bag discards everything and refills the bag.
      cyc(rnd_with(3'd4), 1'b0, 1'b1);
      chk("midreset_piece_v", 32'(piece_v_o), 32'd0);
      chk("midreset_preview_v", 32'(preview_v_o), 32'd0);
      chk("midreset_preview", 32'(preview_o), 32'd0);
      cyc(W'($urandom), 1'b0, 1'b0);
      cyc(rnd_with(3'd0), 1'b0, 1'b0);
      chk("bag_reloaded_v", 32'(piece_v_o), 32'd1);
      chk("bag_reloaded_piece", 32'(piece_o), 32'd0);

`ifdef PIECE_BAG_EN
      exp_p = '{3, 0, 1, 2, 4, 5, 6, 3};
      exp_g = '{8, 8, 8, 8, 8, 8, 1};
`else
      exp_p = '{3, 3, 3, 3, 3, 3, 3, 3};
      exp_g = '{1, 1, 1, 1, 1, 1, 1};
`endif
      exp_first = 2;
      run_seq("held3", 3'd3);

`ifdef PIECE_BAG_EN
      exp_p = '{0, 1, 2, 3, 4, 5, 6, 0};
`else
      exp_p = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif
      exp_g = '{M, M, M, M, M, M, M};
      exp_first = M + 1;
      run_seq("held7", 3'd7);

`ifndef PIECE_BAG_EN
      exp_p = '{2, 2, 2, 2, 2, 2, 2, 2};
      exp_g = '{1, 1, 1, 1, 1, 1, 1};
      exp_first = 2;
      run_seq("held2", 3'd2);
`endif

      // Random traffic with bursts of stalls, rejections and rare resets.
      for (int i = 0; i < 1500; i++) begin
         logic [W-1:0] r;
         logic rdy;
         r = W'($urandom);
         if ($urandom_range(0, 3) == 0) r[2:0] = 3'd7;
         rdy = ((i / 60) % 3 == 2) ? 1'b0 : ($urandom_range(0, 9) < 6);
         cyc(r, rdy, $urandom_range(0, 199) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/piece_bag_scheduler.md
PIECE_BAG_SCHEDULER -- requirements
Module: piece_bag_scheduler

Interface
REQ-001 SHALL have parameter width_p, default 32: width of the random word consumed from the union random generator.
REQ-002 SHALL have parameter depth_p, default 4: piece queue depth (head plus depth_p-1 preview slots); legal range 2..8.
REQ-003 SHALL have parameter max_reject_p, default 8: consecutive rejected draws before the fallback pick.
REQ-004 SHALL have port clk_i, input, 1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset_i, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port random_i, input, width_p: free-running random word; only bits [2:0] are used.
REQ-007 SHALL have port piece_ready_i, input, 1: game logic accepts the head piece.
REQ-008 SHALL have port piece_v_o, output, 1: head piece valid.
REQ-009 SHALL have port piece_o, output, 3: head piece ID (piece_t).
REQ-010 SHALL have port preview_o, output, (depth_p-1)x3: queued pieces behind the head; index 0 is next.
REQ-011 SHALL have port preview_v_o, output, 1: queue full, so all preview slots are valid.

Function
REQ-012 Piece IDs SHALL be 0..6 (I,O,T,S,Z,J,L); candidate = random_i[2:0].
REQ-013 bag_r (7 bits) SHALL mark pieces not yet dealt in the current bag.
REQ-014 Candidate SHALL be accepted when < 7 and its bag_r bit is 1; otherwise rejected and reject_cnt_r incremented.
REQ-015 At most one draw SHALL occur per cycle, only in state FILL and only while queue count < depth_p (or == depth_p with a same-cycle pop).
REQ-016 When reject_cnt_r == max_reject_p-1 and the current candidate is rejected, SHALL instead push the lowest-index set bit of bag_r.
REQ-017 Accept or fallback SHALL push the piece, clear its bag_r bit and zero reject_cnt_r.
REQ-018 When clearing leaves bag_r == 0, bag_r SHALL load 7'h7F in the same cycle.
REQ-019 Pop SHALL occur when piece_v_o & piece_ready_i; the head advances next cycle.
REQ-020 Simultaneous push and pop SHALL leave count unchanged; the pushed piece goes to the tail.
REQ-021 piece_v_o SHALL be (count > 0); preview_v_o SHALL be (count == depth_p); invalid slots SHALL read 0.
REQ-022 FSM states SHALL be: INIT (one cycle after reset, no draw) -> FILL; FILL -> HOLD when full with no pop; HOLD -> FILL on pop.
REQ-023 Latency from reset release to piece_v_o = 1 SHALL be 2 cycles when the first candidate is accepted, and at most max_reject_p+1 cycles in any case.
REQ-024 piece_o and preview_o SHALL be registered; no combinational path from random_i to any output.

Reset
REQ-025 reset_i SHALL force state INIT, count 0, bag_r 7'h7F, reject_cnt_r 0, piece_v_o 0, preview_v_o 0, piece_o 0, preview_o all 0.
REQ-026 Reset asserted mid-operation SHALL discard queued pieces and the partial bag; reset has priority over push and pop.

Configuration
REQ-027 With macro PIECE_BAG_EN defined, SHALL apply 7-bag semantics per REQ-013..018.
REQ-028 Without PIECE_BAG_EN, bag_r SHALL be held at 7'h7F (only candidate 7 rejects, fallback is piece 0); all ports unchanged.

Structure
REQ-029 Package tetris_pkg SHALL hold piece_t (3-bit enum I..L), NUM_PIECES = 7 and BAG_FULL = 7'h7F.
REQ-030 The queue SHALL be a separate sub-module piece_queue (shift-register FIFO with parallel read of all slots); the draw logic and FSM stay in piece_bag_scheduler.

Verification
REQ-031 Reset, then random_i[2:0] = 0,1,2,3,4,5,6 on successive cycles with ready = 0 -> piece_o = 0, preview_o = 1,2,3; preview_v_o = 1 on the 5th cycle after reset release.
REQ-032 random_i[2:0] held at 3 with ready = 1 -> piece 3 dealt once; after max_reject_p rejects the fallback deals 0, then 1 (PIECE_BAG_EN); exactly one of each ID per 7 pops.
REQ-033 Queue full, drive ready = 1 for one cycle with accepted candidate 5 -> count stays 4 and 5 appears in preview_o[2] next cycle.
REQ-034 Assert reset_i for 1 cycle mid-bag (bag_r = 7'h05) -> next cycle piece_v_o = 0, bag_r = 7'h7F.
REQ-035 Drive random_i[2:0] = 7 constantly -> one push every max_reject_p cycles, IDs 0..6 in order, then repeating.
REQ-036 Without PIECE_BAG_EN, random_i[2:0] held at 2 -> every dealt piece is 2, with no rejection stalls.
